// File: rtl/cnn_mac_pkg.sv
// Shared constants and saturation helpers for the CNN multiply-accumulate pipeline.
package cnn_mac_pkg;

  localparam int unsigned A_W_DEF       = 14;
  localparam int unsigned B_W_DEF       = 6;
  localparam int unsigned ACC_W_DEF     = 24;
  localparam int unsigned NUM_STAGE_DEF = 3;

  // Wide enough to hold any ACC_W+1 sum for ACC_W up to 64.
  localparam int unsigned SAT_W = 65;

  typedef logic signed [SAT_W-1:0] wide_t;

  function automatic wide_t acc_max(input int unsigned acc_w);
    return (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t acc_min(input int unsigned acc_w);
    return ~acc_max(acc_w);
  endfunction

  // Clamp an ACC_W+1 sum into the signed ACC_W range; flag whether a clamp happened.
  function automatic wide_t sat_add(input wide_t sum, input int unsigned acc_w,
                                    output logic clamp);
    wide_t res;
    res   = sum;
    clamp = 1'b0;
    if (sum > acc_max(acc_w)) begin
      res   = acc_max(acc_w);
      clamp = 1'b1;
    end else if (sum < acc_min(acc_w)) begin
      res   = acc_min(acc_w);
      clamp = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cnn_mac_pipe_mul.sv
// Signed A_W x B_W multiplier: registered operands plus NUM_STAGE product registers.
module cnn_mac_pipe_mul #(
  parameter int unsigned A_W       = 14,
  parameter int unsigned B_W       = 6,
  parameter int unsigned NUM_STAGE = 3
) (
  input  logic                     clk_i,
  input  logic                     ce_i,
  input  logic signed [A_W-1:0]    a_i,
  input  logic signed [B_W-1:0]    b_i,
  output logic signed [A_W+B_W-1:0] p_o
);

  localparam int unsigned P_W = A_W + B_W;

  logic signed [A_W-1:0] a_q;
  logic signed [B_W-1:0] b_q;
  logic signed [P_W-1:0] p_q [NUM_STAGE];

  // No reset on the datapath so the registers fold into the DSP slice.
  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      p_q[0] <= P_W'(a_q) * P_W'(b_q);
      for (int i = 1; i < int'(NUM_STAGE); i++) begin
        p_q[i] <= p_q[i-1];
      end
    end
  end

  assign p_o = p_q[NUM_STAGE-1];

endmodule

// File: rtl/cnn_mac_pipe.sv
// Pipelined signed MAC with saturating group accumulation and valid/ready flow control.
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int unsigned A_W       = A_W_DEF,
  parameter int unsigned B_W       = B_W_DEF,
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned NUM_STAGE = NUM_STAGE_DEF
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   din0,
  input  logic signed [B_W-1:0]   din1,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] dout,
  output logic                    dout_sat
);

  localparam int unsigned P_W = A_W + B_W;
  localparam int unsigned S_W = ACC_W + 1;
  localparam int unsigned D   = NUM_STAGE + 1;

  logic                    ce_c;
  logic signed [P_W-1:0]   prod;
  logic signed [S_W-1:0]   sum_c;
  logic signed [ACC_W-1:0] clamped_c;
  logic                    clamp_c;

  logic [D-1:0]            vld_q, vld_d, last_q, last_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, dout_q, dout_d;
  logic                    first_q, first_d, sticky_q, sticky_d;
  logic                    out_valid_q, out_valid_d, dout_sat_q, dout_sat_d;

  assign ce_c     = !out_valid_q || out_ready;
  assign in_ready = ce_c;

  cnn_mac_pipe_mul #(
    .A_W       (A_W),
    .B_W       (B_W),
    .NUM_STAGE (NUM_STAGE)
  ) u_mul (
    .clk_i (ap_clk),
    .ce_i  (ce_c),
    .a_i   (din0),
    .b_i   (din1),
    .p_o   (prod)
  );

  always_comb begin
    clamp_c   = 1'b0;
    sum_c     = (first_q ? S_W'(0) : S_W'(acc_q)) + S_W'(prod);
    clamped_c = ACC_W'(sat_add(SAT_W'(sum_c), ACC_W, clamp_c));
  end

  always_comb begin
    vld_d       = vld_q;
    last_d      = last_q;
    acc_d       = acc_q;
    first_d     = first_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q && !out_ready;
    dout_d      = dout_q;
    dout_sat_d  = dout_sat_q;
    if (ce_c) begin
      vld_d  = {vld_q[D-2:0], in_valid};
      last_d = {last_q[D-2:0], in_last};
      // Bubbles leave the accumulator and group state untouched.
      if (vld_q[D-1]) begin
        if (last_q[D-1]) begin
          dout_d      = clamped_c;
          dout_sat_d  = sticky_q | clamp_c;
          out_valid_d = 1'b1;
          first_d     = 1'b1;
          sticky_d    = 1'b0;
        end else begin
          acc_d    = clamped_c;
          first_d  = 1'b0;
          sticky_d = sticky_q | clamp_c;
        end
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q       <= '0;
      last_q      <= '0;
      acc_q       <= '0;
      first_q     <= 1'b1;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      dout_sat_q  <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      dout_sat_q  <= dout_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign dout_sat  = dout_sat_q;

endmodule

// File: doc/cnn_mac_pipe.md
# cnn_mac_pipe

Pipelined, parametrised signed multiply-accumulate unit for CNN convolution layers, replacing fixed-width combinational multipliers in the conv datapath. Multiplies a signed activation by a signed weight through a `NUM_STAGE`-deep registered multiplier, then accumulates products over a dot-product group delimited by `in_last`, with saturation. A valid/ready handshake on both sides lets it sit between a line-buffer reader and the output/requantisation stage, with full backpressure.

## Interface
- `A_W`, 14: activation (din0) width, signed.
- `B_W`, 6: weight (din1) width, signed.
- `ACC_W`, 24: accumulator and result width, signed; must be ≥ `A_W+B_W`.
- `NUM_STAGE`, 3: multiplier pipeline registers, ≥1.

Ports:
- `ap_clk` in 1: clock, all logic on rising edge.
- `ap_rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: unit can accept a beat.
- `din0` in `A_W`: signed activation.
- `din1` in `B_W`: signed weight.
- `in_last` in 1: beat closes the current dot-product group.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts result.
- `dout` out `ACC_W`: saturated group sum.
- `dout_sat` out 1: a clamp occurred somewhere in this group.

## Operation
- Beat accepted when `in_valid && in_ready`. `din0`, `din1`, `in_last` travel together down the pipeline with a valid bit per stage.
- Global enable `ce = !out_valid || out_ready`. `in_ready = ce`. When `ce=0` every pipeline register, the valid bits, the accumulator and the output hold.
- Multiply: exact `A_W+B_W`-bit signed product, no truncation. Sign-extended to `ACC_W+1` before adding.
- Accumulate stage, when the product valid bit is set and `ce=1`:
  - `sum = (first ? 0 : acc) + prod`, computed in `ACC_W+1` bits.
  - Clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. A clamp sets the group's sticky sat flag.
  - Further beats continue from the clamped value.
  - Not last: `acc <= clamped`, `first <= 0`, no output.
  - Last: `dout <= clamped`, `dout_sat <= sticky | clamp_now`, `out_valid <= 1`, `first <= 1`, sticky cleared.
- Holding `in_last=1` on every beat gives one product per output (plain pipelined multiplier mode).
- `out_valid` clears on `out_ready` unless a new result is written the same cycle. Back-to-back results are allowed.
- Reset values: `out_valid=0`, `dout=0`, `dout_sat=0`, `in_ready=1`, `acc=0`, `first=1`, sticky=0, all pipeline valid bits 0.
- Reset mid-group discards all partial sums and in-flight beats.

## Timing
- Latency: a last beat accepted on edge N drives `out_valid=1` after edge N+`NUM_STAGE`+1, provided there are no stalls.
- Throughput: one beat per cycle while `out_ready=1`.
- Stall cycles add exactly one cycle of latency each.
- Backpressure reaches `in_ready` combinationally in the same cycle: `out_valid && !out_ready` forces `in_ready=0`. No skid buffer, so no beat is lost or duplicated.
- `in_valid` may drop mid-group. Bubbles do not affect `acc` or `first`.

## Structure
- Shared package `cnn_mac_pkg` contains:
  - the `ACC_MAX`/`ACC_MIN` constant derivation;
  - the saturating-add function (`ACC_W+1` → `ACC_W`, with clamp flag).
- Sub-module `cnn_mac_pipe_mul` is the signed `A_W`×`B_W` multiplier with `NUM_STAGE` registers and a `ce` input, written for DSP48 inference. Sideband (valid, last) shift registers stay in the top level.

## Test plan
Defaults unless stated: A_W=14, B_W=6, ACC_W=24, NUM_STAGE=3.
- Single beat (−8192, −32, last=1), `out_ready=1` → `dout=262144`, `dout_sat=0`, `out_valid` exactly 4 cycles after acceptance, high for 1 cycle.
- Group (100,3), (−50,2), (7,−7), (1,1) with last on beat 4, then a bubble → one output `dout=152`, no output for beats 1–3.
- 33 beats of (−8192,−32), last on beat 33 → `dout=8388607`, `dout_sat=1`. Next group (1,1,last) → `dout=1`, `dout_sat=0`.
- 10 single-beat groups (i, 2) for i=0..9, `out_ready` low for 5 cycles mid-stream → `in_ready` low while blocked; outputs 0,2,…,18 in order, none lost or duplicated.
- Two non-last beats (5,5), then `ap_rst_n` pulsed low asynchronously → all outputs at reset values immediately. After release, (5,5,last) → `dout=25`.
- NUM_STAGE=1, ACC_W=20, beat (−8192, 31, last) → `dout=−253952`, latency 2 cycles.
